// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx packet arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DRIVE_REQ = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width for an n-entry requester vector (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// rr_priority_picker: requester 0 wins outright, otherwise the first valid
// requester in 1..NREQ-1 searching cyclically from ptr+1.
module rr_priority_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int cand;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    cand     = 0;
    if (valid[IDX_W'(DRIVE_REQ)]) begin
      onehot_c[IDX_W'(DRIVE_REQ)] = 1'b1;
      idx_c                       = IDX_W'(DRIVE_REQ);
      any_c                       = 1'b1;
    end else begin
      // Candidates wrap within 1..NREQ-1, never back onto index 0.
      for (int k = 1; k < int'(NREQ); k++) begin
        cand = int'(ptr) + k;
        if (cand >= int'(NREQ)) cand = cand - (int'(NREQ) - 1);
        if (!any_c && valid[IDX_W'(cand)]) begin
          onehot_c[IDX_W'(cand)] = 1'b1;
          idx_c                  = IDX_W'(cand);
          any_c                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one uart_tx between NREQ byte streams.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 50_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0][BYTE_W-1:0]  req_data,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [NREQ-1:0]              grant,
  output logic                         busy,
  output logic [NREQ-1:0]              timeout_err
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             pick_any;
  logic             slot_free;
  logic             accept;
  logic             pkt_done;
  logic             timeout_hit;
  logic             release_grant;
  logic             lock_next;
  logic             txv_next;

  rr_priority_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx),
    .any_c    (pick_any)
  );

  // The single output slot can take a byte when empty or draining this cycle.
  assign slot_free     = !tx_valid || tx_ready;
  assign req_ready     = (state == LOCKED && slot_free) ? grant : '0;
  assign accept        = (state == LOCKED) && slot_free && req_valid[owner];
  assign pkt_done      = accept && req_last[owner];
  assign release_grant = pkt_done || timeout_hit;
  assign lock_next     = (state == IDLE) ? pick_any : !release_grant;
  assign txv_next      = accept || (tx_valid && !tx_ready);

  // Arbitration FSM and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= IDX_W'(NREQ - 1);
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      busy     <= lock_next || txv_next;
      tx_valid <= txv_next;
      if (accept) tx_data <= req_data[owner];
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= LOCKED;
            grant <= pick_onehot;
            owner <= pick_idx;
            if (pick_idx != IDX_W'(DRIVE_REQ)) rr_ptr <= pick_idx;
          end
        end
        LOCKED: begin
          if (release_grant) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  // Only cycles where the owner could have sent but did not are counted.
  assign stalled     = (state == LOCKED) && slot_free && !req_valid[owner];
  assign timeout_hit = stalled && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || accept) begin
      stall_cnt <= '0;
    end else if (stalled) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= '0;
    end else begin
      timeout_err <= timeout_hit ? grant : '0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign timeout_err    = '0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule
